// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the writeback arbiter slice.
package rf_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned REG_ID_W = 4;
  localparam int unsigned NUM_REGS = 16;

  typedef struct packed {
    logic [REG_ID_W-1:0] dst;
    logic [DATA_W-1:0]   data;
  } rf_wr_t;

  function automatic logic [NUM_REGS-1:0] dst_onehot(input logic [REG_ID_W-1:0] dst);
    dst_onehot      = '0;
    dst_onehot[dst] = 1'b1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback port bundle: pipeline and multi-cycle producers, register-file port, hazard status.
interface rf_wb_arbiter_if
  import rf_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic                pipe_we;
  logic [REG_ID_W-1:0] pipe_dst;
  logic [DATA_W-1:0]   pipe_data;
  logic                mc_valid;
  logic                mc_ready;
  logic [REG_ID_W-1:0] mc_dst;
  logic [DATA_W-1:0]   mc_data;
  logic                rf_WriteReg;
  logic [REG_ID_W-1:0] rf_DstReg;
  logic [DATA_W-1:0]   rf_DstData;
  logic [NUM_REGS-1:0] pend_busy;
  logic [CntW-1:0]     fifo_count;
  logic                stall_req;

  modport master (
    output pipe_we, pipe_dst, pipe_data, mc_valid, mc_dst, mc_data,
    input  mc_ready, rf_WriteReg, rf_DstReg, rf_DstData, pend_busy, fifo_count, stall_req
  );

  modport slave (
    input  pipe_we, pipe_dst, pipe_data, mc_valid, mc_dst, mc_data,
    output mc_ready, rf_WriteReg, rf_DstReg, rf_DstData, pend_busy, fifo_count, stall_req
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of pending register writes; exposes per-slot valid/dst for hazard decode.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_push,
  input  rf_wr_t                              i_wr,
  input  logic                                i_pop,
  output rf_wr_t                              o_head,
  output logic [$clog2(Depth):0]              o_count,
  output logic [Depth-1:0]                    o_ent_valid,
  output logic [Depth-1:0][REG_ID_W-1:0]      o_ent_dst
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  rf_wr_t            r_mem [Depth];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic [Depth-1:0]  r_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      // Clear before set so a push into the slot being popped stays valid.
      if (i_pop) begin
        r_rd_ptr          <= r_rd_ptr + PtrW'(1);
        r_valid[r_rd_ptr] <= 1'b0;
      end
      if (i_push) begin
        r_wr_ptr          <= r_wr_ptr + PtrW'(1);
        r_valid[r_wr_ptr] <= 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wr;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(Depth); i++) begin
      o_ent_dst[i] = r_mem[i].dst;
    end
  end

  assign o_head      = r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_ent_valid = r_valid;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline priority, multi-cycle cut-through and buffering.
// Optional starvation guard enabled by defining RF_WB_STARVE_GUARD_EN.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic                                 w_pipe_live;
  logic                                 w_xfer;
  logic                                 w_fifo_nonempty;
  logic                                 w_cut;
  logic                                 w_push;
  logic                                 w_pop;
  rf_wr_t                               w_head;
  rf_wr_t                               w_mc_wr;
  logic [CntW-1:0]                      w_count;
  logic [FIFO_DEPTH-1:0]                w_ent_valid;
  logic [FIFO_DEPTH-1:0][REG_ID_W-1:0]  w_ent_dst;

  assign w_pipe_live     = bus.pipe_we && (bus.pipe_dst != '0);
  assign w_fifo_nonempty = (w_count != '0);
  // Ready looks only at registered occupancy, so a same-cycle pop never frees a full FIFO.
  assign bus.mc_ready    = !rst && (w_count < CntW'(FIFO_DEPTH));
  assign w_xfer          = bus.mc_valid && bus.mc_ready;
  assign w_mc_wr         = '{dst: bus.mc_dst, data: bus.mc_data};

  always_comb begin
    bus.rf_WriteReg = 1'b0;
    bus.rf_DstReg   = '0;
    bus.rf_DstData  = '0;
    w_pop           = 1'b0;
    w_cut           = 1'b0;
    if (!rst) begin
      if (w_pipe_live) begin
        bus.rf_WriteReg = 1'b1;
        bus.rf_DstReg   = bus.pipe_dst;
        bus.rf_DstData  = bus.pipe_data;
      end else if (w_fifo_nonempty) begin
        bus.rf_WriteReg = 1'b1;
        bus.rf_DstReg   = w_head.dst;
        bus.rf_DstData  = w_head.data;
        w_pop           = 1'b1;
      end else if (w_xfer && (bus.mc_dst != '0)) begin
        bus.rf_WriteReg = 1'b1;
        bus.rf_DstReg   = bus.mc_dst;
        bus.rf_DstData  = bus.mc_data;
        w_cut           = 1'b1;
      end
    end
  end

  // R0 results complete the handshake but are never stored.
  assign w_push = w_xfer && (bus.mc_dst != '0) && !w_cut;

  rf_wb_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_push      (w_push),
    .i_wr        (w_mc_wr),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_ent_valid (w_ent_valid),
    .o_ent_dst   (w_ent_dst)
  );

  assign bus.fifo_count = w_count;

  always_comb begin
    bus.pend_busy = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (w_ent_valid[i]) begin
        bus.pend_busy = bus.pend_busy | dst_onehot(w_ent_dst[i]);
      end
    end
  end

`ifdef RF_WB_STARVE_GUARD_EN
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  logic [StarveW-1:0] r_starve_cnt;
  logic [StarveW-1:0] w_starve_cnt_nxt;
  logic               r_stall;
  logic               w_stall_nxt;

  always_comb begin
    w_starve_cnt_nxt = r_starve_cnt;
    w_stall_nxt      = r_stall;
    if (w_pop) begin
      w_starve_cnt_nxt = '0;
      w_stall_nxt      = 1'b0;
    end else begin
      if (w_fifo_nonempty && w_pipe_live && (r_starve_cnt < StarveW'(STARVE_LIMIT))) begin
        w_starve_cnt_nxt = r_starve_cnt + StarveW'(1);
      end
      if (w_starve_cnt_nxt >= StarveW'(STARVE_LIMIT)) begin
        w_stall_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_cnt_nxt;
      r_stall      <= w_stall_nxt;
    end
  end

  assign bus.stall_req = r_stall;
`else
  logic w_unused_cfg;
  assign w_unused_cfg  = |STARVE_LIMIT;
  assign bus.stall_req = 1'b0;
`endif

  // The hazard unit must hold back a pipe write to a register still waiting in the FIFO.
  pipe_dst_not_pending: assert property (@(posedge clk) disable iff (rst)
    !(w_pipe_live && bus.pend_busy[bus.pipe_dst]));

endmodule
